// File: rtl/mer_estimator.sv
// ---------------------------------------------------------------------------
// mer_estimator
//
// Receive-side MER measurement block. Over a window of 2^LOG2_N symbols it
// accumulates |dec_var|, error^2 and the symbol-error flag. At window end it
// publishes the means and the error count, with a one-clk result_valid pulse.
// A clear_accum pulse (re)starts a window on the next symbol enable.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-high
//   i_sym_clk_en     symbol-rate enable, one clk wide
//   i_clear_accum    window restart pulse, one clk wide
//   i_dec_var        signed 1s17 decision variable
//   i_error          signed 1s17 error sample (dec_var - slicer output)
//   i_sym_error      symbol decision was wrong
//   o_ref_level      1s17 mean |dec_var| (MSB always 0)
//   o_err_power      0.17 mean error^2 (MSB always 0)
//   o_err_count      symbol errors in the last completed window
//   o_result_valid   one-clk pulse when the outputs update
//   o_state          debug: current FSM state (0 = IDLE, 1 = ACCUM)
//
// Handshake: there is no back-pressure. A sample is consumed on every clk
// edge where i_sym_clk_en is 1; o_result_valid is a qualifier pulse that is
// high for exactly one clk after the edge that delivered a window's last
// symbol, and the data outputs hold until the next such pulse.
// ---------------------------------------------------------------------------
module mer_estimator #(
    parameter int LOG2_N = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_sym_clk_en,
    input  logic                i_clear_accum,
    input  logic signed [17:0]  i_dec_var,
    input  logic signed [17:0]  i_error,
    input  logic                i_sym_error,
    output logic [17:0]         o_ref_level,
    output logic [17:0]         o_err_power,
    output logic [LOG2_N:0]     o_err_count,
    output logic                o_result_valid,
    output logic                o_state
);

    localparam int ACCW = 17 + LOG2_N;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic                r_pending;
    logic [LOG2_N-1:0]   r_cnt;
    logic [ACCW-1:0]     r_abs_acc;
    logic [ACCW-1:0]     r_sq_acc;
    logic [LOG2_N:0]     r_err_acc;
    logic [17:0]         r_ref_level;
    logic [17:0]         r_err_power;
    logic [LOG2_N:0]     r_err_count;
    logic                r_result_valid;

    // Per-sample magnitude; -131072 has no positive 17-bit twin, so saturate.
    logic [17:0]         w_neg;
    logic [16:0]         w_abs;
    always_comb begin
        w_neg = 18'(-i_dec_var);
        w_abs = i_dec_var[16:0];
        if (i_dec_var[17]) begin
            w_abs = w_neg[17] ? 17'h1FFFF : w_neg[16:0];
        end
    end

    // Per-sample error power; the product is never negative, and only
    // error = -131072 gives 2^34, whose >>17 would need an 18th bit.
    logic signed [35:0]  w_prod;
    logic [16:0]         w_sq;
    assign w_prod = i_error * i_error;
    assign w_sq   = w_prod[34] ? 17'h1FFFF : w_prod[33:17];

    logic [ACCW-1:0]     w_abs_sum;
    logic [ACCW-1:0]     w_sq_sum;
    logic [LOG2_N:0]     w_err_sum;
    assign w_abs_sum = r_abs_acc + ACCW'(w_abs);
    assign w_sq_sum  = r_sq_acc + ACCW'(w_sq);
    assign w_err_sum = r_err_acc + (LOG2_N+1)'(i_sym_error);

    // A restart happens on a symbol enable with a clear pending or arriving
    // in the same clk; it overrides any window-end dump on that symbol.
    logic w_start;
    logic w_last;
    assign w_start = i_sym_clk_en && (r_pending || i_clear_accum);
    assign w_last  = (r_cnt == {LOG2_N{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_start) w_next_state = ACCUM;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending      <= 1'b0;
            r_cnt          <= '0;
            r_abs_acc      <= '0;
            r_sq_acc       <= '0;
            r_err_acc      <= '0;
            r_ref_level    <= '0;
            r_err_power    <= '0;
            r_err_count    <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_start) begin
                r_pending <= 1'b0;
                r_cnt     <= LOG2_N'(1);
                r_abs_acc <= ACCW'(w_abs);
                r_sq_acc  <= ACCW'(w_sq);
                r_err_acc <= (LOG2_N+1)'(i_sym_error);
            end else begin
                if (i_clear_accum) r_pending <= 1'b1;
                if (i_sym_clk_en && r_state == ACCUM) begin
                    if (w_last) begin
                        r_ref_level    <= {1'b0, w_abs_sum[LOG2_N +: 17]};
                        r_err_power    <= {1'b0, w_sq_sum[LOG2_N +: 17]};
                        r_err_count    <= w_err_sum;
                        r_result_valid <= 1'b1;
                        // Zeroed accumulators make the next symbol behave as
                        // symbol 0 of the following window.
                        r_cnt          <= '0;
                        r_abs_acc      <= '0;
                        r_sq_acc       <= '0;
                        r_err_acc      <= '0;
                    end else begin
                        r_cnt     <= r_cnt + LOG2_N'(1);
                        r_abs_acc <= w_abs_sum;
                        r_sq_acc  <= w_sq_sum;
                        r_err_acc <= w_err_sum;
                    end
                end
            end
        end
    end

    assign o_ref_level    = r_ref_level;
    assign o_err_power    = r_err_power;
    assign o_err_count    = r_err_count;
    assign o_result_valid = r_result_valid;
    assign o_state        = r_state;

endmodule

// File: tb/tb_mer_estimator.sv
module tb_mer_estimator;

  localparam int LOG2_N = 4;
  localparam int N = 1 << LOG2_N;

  logic               clk;
  logic               reset;
  logic               sym_clk_en;
  logic               clear_accum;
  logic signed [17:0] dec_var;
  logic signed [17:0] error;
  logic               sym_error;
  logic [17:0]        ref_level;
  logic [17:0]        err_power;
  logic [LOG2_N:0]    err_count;
  logic               result_valid;
  logic               state;

  int n_cmp;
  int n_err;
  int n_valid;
  logic last_valid;

  mer_estimator #(.LOG2_N(LOG2_N)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_sym_clk_en   (sym_clk_en),
    .i_clear_accum  (clear_accum),
    .i_dec_var      (dec_var),
    .i_error        (error),
    .i_sym_error    (sym_error),
    .o_ref_level    (ref_level),
    .o_err_power    (err_power),
    .o_err_count    (err_count),
    .o_result_valid (result_valid),
    .o_state        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count result_valid pulses; each pulse spans exactly one negedge
  always @(negedge clk) begin
    if (result_valid === 1'b1) n_valid++;
  end

  // driver tasks: drive on negedge, sample 1 time unit after posedge
  task automatic send_sym(input logic signed [17:0] d, input logic signed [17:0] e,
                          input logic se, input logic clr);
    @(negedge clk);
    dec_var = d; error = e; sym_error = se; clear_accum = clr; sym_clk_en = 1'b1;
    @(posedge clk);
    #1;
    last_valid = result_valid;
    sym_clk_en = 1'b0; clear_accum = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_accum = 1'b1; sym_clk_en = 1'b0;
    @(posedge clk);
    #1;
    clear_accum = 1'b0;
  endtask

  task automatic idle_clk();
    @(negedge clk);
    sym_clk_en = 1'b0; clear_accum = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sym_clk_en = 1'b0; clear_accum = 1'b0;
    dec_var = '0; error = '0; sym_error = 1'b0;
    repeat (3) @(posedge clk);
    // enables and clears during reset must have no effect
    @(negedge clk);
    sym_clk_en = 1'b1; clear_accum = 1'b1; dec_var = 18'sd5000; sym_error = 1'b1;
    @(negedge clk);
    sym_clk_en = 1'b0; clear_accum = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ref_level", 32'(ref_level), 32'd0);
    chk("reset_err_power", 32'(err_power), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    chk("reset_valid", 32'(result_valid), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
  endtask

  task automatic test_no_clear();
    int v0 = n_valid;
    for (int i = 0; i < 40; i++) begin
      send_sym(18'($urandom_range(0, 262143)), 18'($urandom_range(0, 262143)),
               1'($urandom_range(0, 1)), 1'b0);
    end
    idle_clk();
    chk("noclear_pulses", 32'(n_valid - v0), 32'd0);
    chk("noclear_ref_level", 32'(ref_level), 32'd0);
    chk("noclear_err_power", 32'(err_power), 32'd0);
    chk("noclear_err_count", 32'(err_count), 32'd0);
    chk("noclear_state", 32'(state), 32'd0);
  endtask

  task automatic test_mean_abs();
    int v0;
    pulse_clear();
    v0 = n_valid;
    for (int i = 0; i < N; i++) begin
      send_sym(18'sd43690, 18'sd0, 1'b0, 1'b0);
      if (i == N - 2) chk("mean_abs_early_valid", 32'(last_valid), 32'd0);
    end
    chk("mean_abs_valid", 32'(last_valid), 32'd1);
    chk("mean_abs_ref_level", 32'(ref_level), 32'd43690);
    chk("mean_abs_err_power", 32'(err_power), 32'd0);
    chk("mean_abs_err_count", 32'(err_count), 32'd0);
    idle_clk();
    chk("mean_abs_valid_drop", 32'(result_valid), 32'd0);
    chk("mean_abs_hold", 32'(ref_level), 32'd43690);
    chk("mean_abs_pulses", 32'(n_valid - v0), 32'd1);
  endtask

  task automatic test_full_scale();
    pulse_clear();
    for (int i = 0; i < N; i++) begin
      send_sym((i % 2 == 0) ? 18'sd131071 : -18'sd131072, 18'sd65536, 1'b0, 1'b0);
    end
    chk("full_scale_valid", 32'(last_valid), 32'd1);
    chk("full_scale_ref_level", 32'(ref_level), 32'd131071);
    chk("full_scale_err_power", 32'(err_power), 32'd32768);
    chk("full_scale_err_count", 32'(err_count), 32'd0);
  endtask

  task automatic test_sat_errors();
    pulse_clear();
    for (int i = 0; i < N; i++) begin
      send_sym(-18'sd1000, -18'sd131072, (i == 0 || i == 3 || i == 7 || i == 12 || i == 15), 1'b0);
    end
    chk("sat_valid", 32'(last_valid), 32'd1);
    chk("sat_ref_level", 32'(ref_level), 32'd1000);
    chk("sat_err_power", 32'(err_power), 32'd131071);
    chk("sat_err_count", 32'(err_count), 32'd5);
  endtask

  task automatic test_abort();
    int v0;
    pulse_clear();
    v0 = n_valid;
    for (int i = 0; i < 7; i++) send_sym(18'sd50000, 18'sd0, 1'b1, 1'b0);
    pulse_clear();                                    // abort at symbol 7
    for (int i = 0; i < 3; i++) send_sym(18'sd50000, 18'sd0, 1'b1, 1'b0);
    send_sym(18'sd2000, 18'sd0, 1'b0, 1'b1);          // clear with enable: symbol 0
    for (int i = 1; i < N; i++) begin
      send_sym(18'sd2000, 18'sd0, (i < 3), 1'b0);
      if (i == N - 2) chk("abort_early_valid", 32'(last_valid), 32'd0);
    end
    chk("abort_valid", 32'(last_valid), 32'd1);
    chk("abort_pulses", 32'(n_valid - v0), 32'd0);    // pulse not yet sampled by monitor
    idle_clk();
    chk("abort_pulses_after", 32'(n_valid - v0), 32'd1);
    chk("abort_ref_level", 32'(ref_level), 32'd2000);
    chk("abort_err_count", 32'(err_count), 32'd2);
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    // continuous: next window starts without a clear
    for (int i = 0; i < N; i++) send_sym(18'sd300, 18'sd4096, 1'b0, 1'b0);
    chk("b2b_valid", 32'(last_valid), 32'd1);
    chk("b2b_ref_level", 32'(ref_level), 32'd300);
    chk("b2b_err_power", 32'(err_power), 32'd128);
    // clear pending at the window-end symbol aborts that window
    for (int i = 0; i < N - 1; i++) send_sym(18'sd900, 18'sd0, 1'b0, 1'b0);
    pulse_clear();
    send_sym(18'sd600, 18'sd0, 1'b1, 1'b0);
    chk("pend_end_valid", 32'(last_valid), 32'd0);
    for (int i = 1; i < N; i++) send_sym(18'sd600, 18'sd0, 1'b0, 1'b0);
    chk("pend_restart_valid", 32'(last_valid), 32'd1);
    chk("pend_restart_ref_level", 32'(ref_level), 32'd600);
    chk("pend_restart_err_count", 32'(err_count), 32'd1);
    idle_clk();
    chk("b2b_pulses", 32'(n_valid - v0), 32'd2);
  endtask

  task automatic test_reset_mid();
    int v0;
    pulse_clear();
    for (int i = 0; i < 9; i++) send_sym(18'sd5000, 18'sd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1; sym_clk_en = 1'b1; dec_var = 18'sd5000;
    @(posedge clk);
    #1;
    reset = 1'b0; sym_clk_en = 1'b0;
    chk("rmid_ref_level", 32'(ref_level), 32'd0);
    chk("rmid_err_power", 32'(err_power), 32'd0);
    chk("rmid_err_count", 32'(err_count), 32'd0);
    chk("rmid_state", 32'(state), 32'd0);
    v0 = n_valid;
    for (int i = 0; i < 20; i++) send_sym(18'sd5000, 18'sd0, 1'b0, 1'b0);
    idle_clk();
    chk("rmid_no_pulse", 32'(n_valid - v0), 32'd0);
    pulse_clear();
    for (int i = 0; i < N; i++) send_sym(-18'sd777, 18'sd0, (i == 5), 1'b0);
    chk("rmid_restart_valid", 32'(last_valid), 32'd1);
    chk("rmid_restart_ref_level", 32'(ref_level), 32'd777);
    chk("rmid_restart_err_count", 32'(err_count), 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_valid = 0; last_valid = 1'b0;
    test_reset();
    test_no_clear();
    test_mean_abs();
    test_full_scale();
    test_sat_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    idle_clk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
